// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing with
// a memory ready handshake, illegal-opcode trap and memory-timeout bus error.
//
// Optional feature macro: JUMP_CTRL_EN (adds the JUMP state for opcode j).
//
// Ports:
//   Clock, Reset         rising-edge clock, asynchronous active-high reset
//   Op_Code, Function    IR[31:26] / IR[5:0]
//   Zero                 ALU zero flag (branch condition)
//   Memory_Ready         memory completes current access this cycle
//   PC_Write, IR_Write   PC / IR load enables
//   I_or_D               memory address select (0 PC, 1 ALUOut)
//   Memory_Read/Write    memory requests, held until Memory_Ready
//   Memory_to_Register   write-back data from MDR
//   ALU_Source_A/B       ALU operand selects
//   ALU_Control          ALU op (0 add .. 7 sltu), zero-extended
//   PC_Source            0 ALU, 1 ALUOut, 2 jump target
//   Register_Destination 1 rd, 0 rt
//   Register_Write       register-file write enable
//   Sign_Zero            1 sign-extend imm, 0 zero-extend
//   Illegal_Instruction  sticky illegal-opcode flag
//   Bus_Error            sticky memory-timeout flag
module multi_cycle_controller #(
   parameter int ALU_CTRL_WIDTH = 3,
   parameter int WAIT_LIMIT     = 15
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic [5:0]                Op_Code,
   input  logic [5:0]                Function,
   input  logic                      Zero,
   input  logic                      Memory_Ready,
   output logic                      PC_Write,
   output logic                      IR_Write,
   output logic                      I_or_D,
   output logic                      Memory_Read,
   output logic                      Memory_Write,
   output logic                      Memory_to_Register,
   output logic                      ALU_Source_A,
   output logic [1:0]                ALU_Source_B,
   output logic [ALU_CTRL_WIDTH-1:0] ALU_Control,
   output logic [1:0]                PC_Source,
   output logic                      Register_Destination,
   output logic                      Register_Write,
   output logic                      Sign_Zero,
   output logic                      Illegal_Instruction,
   output logic                      Bus_Error
);

   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_EXECUTE   = 4'd2;
   localparam logic [3:0] S_ALU_WB    = 4'd3;
   localparam logic [3:0] S_IMM_EXEC  = 4'd4;
   localparam logic [3:0] S_IMM_WB    = 4'd5;
   localparam logic [3:0] S_MEM_ADDR  = 4'd6;
   localparam logic [3:0] S_MEM_READ  = 4'd7;
   localparam logic [3:0] S_MEM_WRITE = 4'd8;
   localparam logic [3:0] S_MEM_WB    = 4'd9;
   localparam logic [3:0] S_BRANCH    = 4'd10;
   localparam logic [3:0] S_TRAP      = 4'd11;
`ifdef JUMP_CTRL_EN
   localparam logic [3:0] S_JUMP      = 4'd12;
   localparam logic [5:0] OP_J        = 6'b000010;
`endif

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   // Last wait cycle index; a miss here is the timeout.
   localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

   logic [3:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [5:0] op_q, op_d;
   logic [5:0] fn_q, fn_d;
   logic       ill_q, ill_d;
   logic       bus_q, bus_d;
   logic       r_legal;
   logic [2:0] alu_c;

   function automatic logic [2:0] r_alu(input logic [5:0] f);
      case (f)
         6'h22, 6'h23: r_alu = 3'd1;
         6'h24:        r_alu = 3'd2;
         6'h25:        r_alu = 3'd3;
         6'h26:        r_alu = 3'd4;
         6'h27:        r_alu = 3'd5;
         6'h2A:        r_alu = 3'd6;
         6'h2B:        r_alu = 3'd7;
         default:      r_alu = 3'd0;
      endcase
   endfunction

   function automatic logic [2:0] i_alu(input logic [5:0] o);
      case (o)
         6'b001010: i_alu = 3'd6;
         6'b001011: i_alu = 3'd7;
         6'b001100: i_alu = 3'd2;
         6'b001101: i_alu = 3'd3;
         6'b001110: i_alu = 3'd4;
         default:   i_alu = 3'd0;
      endcase
   endfunction

   assign r_legal = Function inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                     6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      fn_d    = fn_q;
      ill_d   = ill_q;
      bus_d   = bus_q;
      case (state_q)
         S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
            if (Memory_Ready) begin
               if (state_q == S_FETCH)
                  state_d = S_DECODE;
               else if (state_q == S_MEM_READ)
                  state_d = S_MEM_WB;
               else
                  state_d = S_FETCH;
            end else if (cnt_q == LAST_WAIT) begin
               state_d = S_TRAP;
               bus_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DECODE: begin
            op_d = Op_Code;
            fn_d = Function;
            case (Op_Code)
               OP_RTYPE:       state_d = r_legal ? S_EXECUTE : S_TRAP;
               OP_LW, OP_SW:   state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               6'b001000, 6'b001001, 6'b001010, 6'b001011,
               6'b001100, 6'b001101, 6'b001110:
                               state_d = S_IMM_EXEC;
`ifdef JUMP_CTRL_EN
               OP_J:           state_d = S_JUMP;
`endif
               default:        state_d = S_TRAP;
            endcase
            if (state_d == S_TRAP)
               ill_d = 1'b1;
         end
         S_EXECUTE:  state_d = S_ALU_WB;
         S_IMM_EXEC: state_d = S_IMM_WB;
         S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_ALU_WB, S_IMM_WB, S_MEM_WB, S_BRANCH:
                     state_d = S_FETCH;
`ifdef JUMP_CTRL_EN
         S_JUMP:     state_d = S_FETCH;
`endif
         default:    state_d = state_q;
      endcase
      // Every state change restarts the wait count, covering entry
      // into all three memory states.
      if (state_d != state_q)
         cnt_d = '0;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         op_q    <= '0;
         fn_q    <= '0;
         ill_q   <= 1'b0;
         bus_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         fn_q    <= fn_d;
         ill_q   <= ill_d;
         bus_q   <= bus_d;
      end
   end

   always_comb begin
      PC_Write             = 1'b0;
      IR_Write             = 1'b0;
      I_or_D               = 1'b0;
      Memory_Read          = 1'b0;
      Memory_Write         = 1'b0;
      Memory_to_Register   = 1'b0;
      ALU_Source_A         = 1'b0;
      ALU_Source_B         = 2'd0;
      alu_c                = 3'd0;
      PC_Source            = 2'd0;
      Register_Destination = 1'b0;
      Register_Write       = 1'b0;
      Sign_Zero            = 1'b0;
      case (state_q)
         S_FETCH: begin
            Memory_Read  = 1'b1;
            ALU_Source_B = 2'd1;
            if (Memory_Ready) begin
               IR_Write = 1'b1;
               PC_Write = 1'b1;
            end
         end
         S_DECODE: begin
            ALU_Source_B = 2'd3;
            Sign_Zero    = 1'b1;
         end
         S_EXECUTE: begin
            ALU_Source_A = 1'b1;
            alu_c        = r_alu(fn_q);
         end
         S_ALU_WB: begin
            Register_Write       = 1'b1;
            Register_Destination = 1'b1;
         end
         S_IMM_EXEC, S_IMM_WB: begin
            ALU_Source_A   = 1'b1;
            ALU_Source_B   = 2'd2;
            alu_c          = i_alu(op_q);
            Sign_Zero      = op_q inside {6'b001000, 6'b001001,
                                          6'b001010, 6'b001011};
            Register_Write = (state_q == S_IMM_WB);
         end
         S_MEM_ADDR: begin
            ALU_Source_A = 1'b1;
            ALU_Source_B = 2'd2;
            Sign_Zero    = 1'b1;
         end
         S_MEM_READ: begin
            I_or_D      = 1'b1;
            Memory_Read = 1'b1;
         end
         S_MEM_WRITE: begin
            I_or_D       = 1'b1;
            Memory_Write = 1'b1;
         end
         S_MEM_WB: begin
            Register_Write     = 1'b1;
            Memory_to_Register = 1'b1;
         end
         S_BRANCH: begin
            ALU_Source_A = 1'b1;
            alu_c        = 3'd1;
            PC_Source    = 2'd1;
            // bne is the only branch with op bit 0 set.
            PC_Write     = op_q[0] ? ~Zero : Zero;
         end
`ifdef JUMP_CTRL_EN
         S_JUMP: begin
            PC_Write  = 1'b1;
            PC_Source = 2'd2;
         end
`endif
         default: ;
      endcase
   end

   assign ALU_Control         = ALU_CTRL_WIDTH'(alu_c);
   assign Illegal_Instruction = ill_q;
   assign Bus_Error           = bus_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomized instruction-stream bench for multi_cycle_controller.
// Expectations come from an instruction table and per-phase output rules.
module tb_multi_cycle_controller;

   localparam int WL = 4;
   localparam int AW = 4;

   localparam int K_R   = 0;
   localparam int K_I   = 1;
   localparam int K_LW  = 2;
   localparam int K_SW  = 3;
   localparam int K_BEQ = 4;
   localparam int K_BNE = 5;
   localparam int K_J   = 6;
   localparam int K_ILL = 7;

   logic          Clock = 1'b0;
   logic          Reset;
   logic [5:0]    Op_Code, Function;
   logic          Zero, Memory_Ready;
   logic          PC_Write, IR_Write, I_or_D, Memory_Read, Memory_Write;
   logic          Memory_to_Register, ALU_Source_A;
   logic [1:0]    ALU_Source_B, PC_Source;
   logic [AW-1:0] ALU_Control;
   logic          Register_Destination, Register_Write, Sign_Zero;
   logic          Illegal_Instruction, Bus_Error;

   typedef struct packed {
      logic          pcw;
      logic          irw;
      logic          iord;
      logic          mrd;
      logic          mwr;
      logic          m2r;
      logic          srca;
      logic [1:0]    srcb;
      logic [AW-1:0] alu;
      logic [1:0]    pcs;
      logic          rdst;
      logic          rw;
      logic          sz;
      logic          ill;
      logic          bus;
   } ov_t;

   typedef struct {
      logic [5:0]    op;
      logic [5:0]    fn;
      int            kind;
      logic [AW-1:0] alu;
      bit            sz;
   } ins_t;

   ins_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   ill_m = 1'b0;
   bit   bus_m = 1'b0;

   always #5 Clock = ~Clock;

   multi_cycle_controller #(
      .ALU_CTRL_WIDTH(AW),
      .WAIT_LIMIT    (WL)
   ) dut (
      .Clock               (Clock),
      .Reset               (Reset),
      .Op_Code             (Op_Code),
      .Function            (Function),
      .Zero                (Zero),
      .Memory_Ready        (Memory_Ready),
      .PC_Write            (PC_Write),
      .IR_Write            (IR_Write),
      .I_or_D              (I_or_D),
      .Memory_Read         (Memory_Read),
      .Memory_Write        (Memory_Write),
      .Memory_to_Register  (Memory_to_Register),
      .ALU_Source_A        (ALU_Source_A),
      .ALU_Source_B        (ALU_Source_B),
      .ALU_Control         (ALU_Control),
      .PC_Source           (PC_Source),
      .Register_Destination(Register_Destination),
      .Register_Write      (Register_Write),
      .Sign_Zero           (Sign_Zero),
      .Illegal_Instruction (Illegal_Instruction),
      .Bus_Error           (Bus_Error)
   );

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic ov_t got_v();
      ov_t g;
      g.pcw  = PC_Write;
      g.irw  = IR_Write;
      g.iord = I_or_D;
      g.mrd  = Memory_Read;
      g.mwr  = Memory_Write;
      g.m2r  = Memory_to_Register;
      g.srca = ALU_Source_A;
      g.srcb = ALU_Source_B;
      g.alu  = ALU_Control;
      g.pcs  = PC_Source;
      g.rdst = Register_Destination;
      g.rw   = Register_Write;
      g.sz   = Sign_Zero;
      g.ill  = Illegal_Instruction;
      g.bus  = Bus_Error;
      return g;
   endfunction

   function automatic ov_t fetch_base();
      ov_t e = '0;
      e.mrd  = 1'b1;
      e.srcb = 2'd1;
      return e;
   endfunction

   // One clock: check at negedge, then re-randomize don't-care inputs.
   task automatic cyc(string tag, ov_t e);
      @(negedge Clock);
      e.ill = ill_m;
      e.bus = bus_m;
      check(tag, 32'(got_v()), 32'(e));
      @(posedge Clock);
      #1;
      Memory_Ready = 1'($urandom);
      Zero         = 1'($urandom);
   endtask

   task automatic do_reset();
      Reset        = 1'b1;
      Memory_Ready = 1'b0;
      ill_m        = 1'b0;
      bus_m        = 1'b0;
      cyc("reset", fetch_base());
      Reset = 1'b0;
   endtask

   task automatic trap_and_reset(int n);
      for (int i = 0; i < n; i++)
         cyc("trap", '0);
      do_reset();
   endtask

   // Memory access with Memory_Ready first high after dly waits.
   task automatic mem_phase(string tag, bit fetch, int dly, ov_t base,
                            output bit ok);
      ov_t e;
      ok = 1'b0;
      for (int i = 0; i < WL; i++) begin
         Memory_Ready = (i == dly);
         e = base;
         if (fetch && (i == dly)) begin
            e.irw = 1'b1;
            e.pcw = 1'b1;
         end
         cyc(tag, e);
         if (i == dly) begin
            ok = 1'b1;
            return;
         end
      end
      bus_m = 1'b1;
   endtask

   task automatic classify(logic [5:0] op, logic [5:0] fn, output int kind,
                           output logic [AW-1:0] alu, output bit sz);
      kind = K_ILL;
      alu  = '0;
      sz   = 1'b0;
      foreach (tbl[i]) begin
         if (tbl[i].op == op && (op != 6'd0 || tbl[i].fn == fn)) begin
            kind = tbl[i].kind;
            alu  = tbl[i].alu;
            sz   = tbl[i].sz;
         end
      end
   endtask

   task automatic run_instr(logic [5:0] op, logic [5:0] fn, int fd, int md,
                            int zf, int tn);
      ov_t e;
      bit ok;
      int kind;
      logic [AW-1:0] alu;
      bit sz;
      classify(op, fn, kind, alu, sz);
      Op_Code  = 6'($urandom);
      Function = 6'($urandom);
      mem_phase("fetch", 1'b1, fd, fetch_base(), ok);
      if (!ok) begin
         trap_and_reset(tn);
         return;
      end
      Op_Code  = op;
      Function = fn;
      e = '0;
      e.srcb = 2'd3;
      e.sz   = 1'b1;
      cyc("decode", e);
      case (kind)
         K_R: begin
            e = '0;
            e.srca = 1'b1;
            e.alu  = alu;
            cyc("execute", e);
            e = '0;
            e.rw   = 1'b1;
            e.rdst = 1'b1;
            cyc("alu_wb", e);
         end
         K_I: begin
            e = '0;
            e.srca = 1'b1;
            e.srcb = 2'd2;
            e.alu  = alu;
            e.sz   = sz;
            cyc("imm_exec", e);
            e.rw = 1'b1;
            cyc("imm_wb", e);
         end
         K_LW, K_SW: begin
            e = '0;
            e.srca = 1'b1;
            e.srcb = 2'd2;
            e.sz   = 1'b1;
            cyc("mem_addr", e);
            e = '0;
            e.iord = 1'b1;
            e.mrd  = (kind == K_LW);
            e.mwr  = (kind == K_SW);
            mem_phase("mem_access", 1'b0, md, e, ok);
            if (!ok) begin
               trap_and_reset(tn);
               return;
            end
            if (kind == K_LW) begin
               e = '0;
               e.rw  = 1'b1;
               e.m2r = 1'b1;
               cyc("mem_wb", e);
            end
         end
         K_BEQ, K_BNE: begin
            Zero = (zf < 0) ? 1'($urandom) : 1'(zf);
            e = '0;
            e.srca = 1'b1;
            e.alu  = AW'(1);
            e.pcs  = 2'd1;
            e.pcw  = (kind == K_BEQ) ? Zero : ~Zero;
            cyc("branch", e);
         end
         K_J: begin
            e = '0;
            e.pcw = 1'b1;
            e.pcs = 2'd2;
            cyc("jump", e);
         end
         default: begin
            ill_m = 1'b1;
            trap_and_reset(tn);
         end
      endcase
   endtask

   task automatic add_ins(logic [5:0] op, logic [5:0] fn, int kind,
                          int alu, bit sz);
      ins_t t;
      t.op   = op;
      t.fn   = fn;
      t.kind = kind;
      t.alu  = AW'(alu);
      t.sz   = sz;
      tbl.push_back(t);
   endtask

   function automatic int rdly();
      if ($urandom_range(0, 11) == 0)
         return WL;
      return $urandom_range(0, WL - 1);
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      ov_t e;
      ins_t t;
      add_ins(6'h00, 6'h20, K_R, 0, 0);
      add_ins(6'h00, 6'h21, K_R, 0, 0);
      add_ins(6'h00, 6'h22, K_R, 1, 0);
      add_ins(6'h00, 6'h23, K_R, 1, 0);
      add_ins(6'h00, 6'h24, K_R, 2, 0);
      add_ins(6'h00, 6'h25, K_R, 3, 0);
      add_ins(6'h00, 6'h26, K_R, 4, 0);
      add_ins(6'h00, 6'h27, K_R, 5, 0);
      add_ins(6'h00, 6'h2A, K_R, 6, 0);
      add_ins(6'h00, 6'h2B, K_R, 7, 0);
      add_ins(6'b001000, 6'h0, K_I, 0, 1);
      add_ins(6'b001001, 6'h0, K_I, 0, 1);
      add_ins(6'b001010, 6'h0, K_I, 6, 1);
      add_ins(6'b001011, 6'h0, K_I, 7, 1);
      add_ins(6'b001100, 6'h0, K_I, 2, 0);
      add_ins(6'b001101, 6'h0, K_I, 3, 0);
      add_ins(6'b001110, 6'h0, K_I, 4, 0);
      add_ins(6'b100011, 6'h0, K_LW, 0, 0);
      add_ins(6'b101011, 6'h0, K_SW, 0, 0);
      add_ins(6'b000100, 6'h0, K_BEQ, 0, 0);
      add_ins(6'b000101, 6'h0, K_BNE, 0, 0);
`ifdef JUMP_CTRL_EN
      add_ins(6'b000010, 6'h0, K_J, 0, 0);
`endif

      Reset        = 1'b1;
      Op_Code      = '0;
      Function     = '0;
      Zero         = 1'b0;
      Memory_Ready = 1'b0;
      @(posedge Clock);
      #1;
      do_reset();

      run_instr(6'h00, 6'h20, 0, 0, -1, 3);
      run_instr(6'b100011, 6'h0, 0, 3, -1, 3);
      run_instr(6'b000100, 6'h0, 0, 0, 1, 3);
      run_instr(6'b000101, 6'h0, 0, 0, 1, 3);
      run_instr(6'b111111, 6'h0, 0, 0, -1, 20);
      run_instr(6'h00, 6'h22, WL, 0, -1, 3);
      run_instr(6'h00, 6'h25, WL - 1, 0, -1, 3);
      run_instr(6'b101011, 6'h0, 0, WL, -1, 3);
      run_instr(6'b000010, 6'h0, 0, 0, -1, 4);

      // Reset while a load is waiting on memory.
      Memory_Ready = 1'b1;
      e = fetch_base();
      e.irw = 1'b1;
      e.pcw = 1'b1;
      cyc("mid_fetch", e);
      Op_Code = 6'b100011;
      e = '0;
      e.srcb = 2'd3;
      e.sz   = 1'b1;
      cyc("mid_decode", e);
      e = '0;
      e.srca = 1'b1;
      e.srcb = 2'd2;
      e.sz   = 1'b1;
      cyc("mid_addr", e);
      Memory_Ready = 1'b0;
      e = '0;
      e.iord = 1'b1;
      e.mrd  = 1'b1;
      cyc("mid_read", e);
      do_reset();

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            run_instr(6'($urandom), 6'($urandom), rdly(), rdly(), -1,
                      $urandom_range(1, 4));
         end else begin
            t = tbl[$urandom_range(0, tbl.size() - 1)];
            run_instr(t.op, t.fn, rdly(), rdly(), -1, $urandom_range(1, 4));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
